// File: rtl/ring_chaser_monitor.sv
// ring_chaser_monitor
//   Receive-side checker for a 6-bit one-hot ring chaser. The ring is sampled
//   through a synchronizer, and each change of the synchronized value is
//   checked against the chaser's rotation bit5->bit0->bit1->...->bit5.
//   Reports the phase index, lock/fault status, a sticky error flag and a
//   2-bit lap counter on a TinyTapeout-style 8-in/8-out slot.
//
//   Optional feature macro: RING_GLITCH_FILTER_EN
//     defined   : the synchronized ring must be stable for two consecutive
//                 clocks before a change is accepted (one extra clock latency).
//     undefined : every change of the synchronized ring is an event.
//
//   io_in[0]   clk
//   io_in[1]   rst (synchronous, active-high)
//   io_in[7:2] ring[5:0] (asynchronous to clk)
//   io_out     {laps[1:0], err_sticky, fault, locked, phase[2:0]}

module ring_chaser_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_COUNT  = 3
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    // Out-of-range parameters are clamped so the structure stays legal:
    // at least two synchronizer flops, and a lock count within 1..7.
    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int LOCK_N = (LOCK_COUNT < 1) ? 1 : ((LOCK_COUNT > 7) ? 7 : LOCK_COUNT);
    localparam logic [2:0] LOCK_LAST = 3'(LOCK_N - 1);

    localparam logic [5:0] RING_HOME = 6'b100000;  // chaser reset pattern
    localparam logic [5:0] RING_WRAP = 6'b000001;  // value after bit5 wraps

    typedef enum logic [1:0] {
        ST_SEARCH = 2'b00,
        ST_LOCKED = 2'b01,
        ST_FAULT  = 2'b10
    } state_t;

    // Slot pin mapping
    logic       clk;
    logic       rst;
    logic [5:0] ring_raw;

    assign clk      = io_in[0];
    assign rst      = io_in[1];
    assign ring_raw = io_in[7:2];

    // State
    logic [5:0] sync_p [SYNC_N];
    logic [5:0] ring_s;
    logic [5:0] prev;
    state_t     state;
    state_t     state_n;
    logic [2:0] good_cnt;
    logic [2:0] good_cnt_n;
    logic [1:0] laps;
    logic [1:0] laps_n;
    logic       err_sticky;
    logic       err_sticky_n;

    // Qualification
    logic       stable;
    logic       ring_event;
    logic       legal_step;
    logic       at_home;

    // True when exactly one bit of v is set.
    function automatic logic is_onehot(input logic [5:0] v);
        int ones;
        ones = 0;
        for (int b = 0; b < 6; b++) begin
            ones = ones + int'(v[b]);
        end
        return (ones == 1);
    endfunction

    // Value the chaser presents one step after v.
    function automatic logic [5:0] ring_next(input logic [5:0] v);
        return {v[4:0], v[5]};
    endfunction

    // Position of the set bit; 7 for zero or multi-hot values.
    function automatic logic [2:0] phase_index(input logic [5:0] v);
        logic [2:0] idx;
        case (v)
            6'b000001: idx = 3'd0;
            6'b000010: idx = 3'd1;
            6'b000100: idx = 3'd2;
            6'b001000: idx = 3'd3;
            6'b010000: idx = 3'd4;
            6'b100000: idx = 3'd5;
            default:   idx = 3'd7;
        endcase
        return idx;
    endfunction

    // Synchronizer chain bringing the asynchronous ring into the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_N; i++) begin
                sync_p[i] <= 6'b000000;
            end
        end else begin
            sync_p[0] <= ring_raw;
            for (int i = 1; i < SYNC_N; i++) begin
                sync_p[i] <= sync_p[i-1];
            end
        end
    end

    assign ring_s = sync_p[SYNC_N-1];

`ifdef RING_GLITCH_FILTER_EN
    logic [5:0] ring_d;

    // Delayed copy of ring_s; a value is qualified only once it has been seen twice.
    always_ff @(posedge clk) begin
        if (rst) begin
            ring_d <= 6'b000000;
        end else begin
            ring_d <= ring_s;
        end
    end

    assign stable = (ring_s == ring_d);
`else
    assign stable = 1'b1;
`endif

    assign ring_event = stable && (ring_s != prev);
    assign legal_step = is_onehot(ring_s) && (ring_s == ring_next(prev));
    assign at_home    = stable && (ring_s == RING_HOME);

    // Next-state, lock counter, lap counter and sticky error decisions.
    always_comb begin
        state_n      = state;
        good_cnt_n   = good_cnt;
        laps_n       = laps;
        err_sticky_n = err_sticky;
        case (state)
            ST_SEARCH: begin
                if (ring_event) begin
                    if (legal_step) begin
                        if (good_cnt == LOCK_LAST) begin
                            state_n    = ST_LOCKED;
                            good_cnt_n = 3'd0;
                        end else begin
                            good_cnt_n = good_cnt + 3'd1;
                        end
                    end else begin
                        // Errors while still hunting for lock are not latched.
                        good_cnt_n = 3'd0;
                    end
                end
            end
            ST_LOCKED: begin
                if (ring_event) begin
                    if (legal_step) begin
                        if (ring_s == RING_WRAP) begin
                            laps_n = laps + 2'd1;
                        end
                    end else begin
                        state_n      = ST_FAULT;
                        err_sticky_n = 1'b1;
                    end
                end
            end
            ST_FAULT: begin
                // Wait for the chaser to be reset before hunting again;
                // the lap count survives the fault.
                if (at_home) begin
                    state_n    = ST_SEARCH;
                    good_cnt_n = 3'd0;
                end
            end
            default: begin
                state_n    = ST_SEARCH;
                good_cnt_n = 3'd0;
            end
        endcase
    end

    // Register state, counters and the last accepted ring value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_SEARCH;
            good_cnt   <= 3'd0;
            laps       <= 2'd0;
            err_sticky <= 1'b0;
            prev       <= 6'b000000;
        end else begin
            state      <= state_n;
            good_cnt   <= good_cnt_n;
            laps       <= laps_n;
            err_sticky <= err_sticky_n;
            // prev follows every qualified value, including illegal ones,
            // so the phase output shows where the ring actually went.
            if (stable) begin
                prev <= ring_s;
            end
        end
    end

    // Outputs decode registers only; no path from io_in reaches io_out.
    always_comb begin
        io_out = {laps,
                  err_sticky,
                  (state == ST_FAULT),
                  (state == ST_LOCKED),
                  phase_index(prev)};
    end

endmodule

// File: tb/tb_ring_chaser_monitor.sv
// Directed bench for ring_chaser_monitor: reset, lock acquisition, lap
// counting, fault entry/exit, search count restart and reset during lock.
// Expected io_out values are written as {laps, err, fault, locked, phase}.

module tb_ring_chaser_monitor;

`ifdef RING_GLITCH_FILTER_EN
    localparam int L = 4;
`else
    localparam int L = 3;
`endif

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic [5:0] ring = 6'b100000;
    logic [7:0] io_in;
    logic [7:0] io_out;

    int total = 0;
    int bad   = 0;

    assign io_in = {ring, rst, clk};

    ring_chaser_monitor #(
        .SYNC_STAGES(2),
        .LOCK_COUNT (3)
    ) dut (
        .io_in (io_in),
        .io_out(io_out)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pack(input logic [1:0] lp, input logic e,
                                        input logic f, input logic lk,
                                        input logic [2:0] ix);
        return {lp, e, f, lk, ix};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step(input logic [5:0] r);
        ring = r;
        tick(4);
    endtask

    task automatic chk(input string tag, input logic [7:0] exp);
        total++;
        assert (io_out === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%02h expected=%02h", tag, io_out, exp);
        end
    endtask

    initial begin : stim
        logic [5:0] cur;
        logic [1:0] lp;
        logic [2:0] ix;

        // Reset held with the chaser at its home pattern
        @(negedge clk);
        rst  = 1'b1;
        ring = 6'b100000;
        tick(2);
        chk("reset", 8'h07);

        rst = 1'b0;
        tick(L - 1);
        chk("rst_latency_hold", 8'h07);
        tick(1);
        chk("rst_release", 8'h05);
        tick(2);

        // Lock acquisition: three legal steps
        step(6'b000001);
        chk("lock_step1", 8'h00);
        step(6'b000010);
        chk("lock_step2", 8'h01);
        ring = 6'b000100;
        tick(L - 1);
        chk("lock_early", 8'h01);
        tick(1);
        chk("lock_enter", 8'h0A);
        tick(1);

        // Twelve legal steps through two wraps
        cur = 6'b000100;
        lp  = 2'd0;
        ix  = 3'd2;
        for (int k = 0; k < 12; k++) begin
            cur = {cur[4:0], cur[5]};
            ix  = (ix == 3'd5) ? 3'd0 : ix + 3'd1;
            if (ix == 3'd0) lp = lp + 2'd1;
            step(cur);
            chk("lap_step", pack(lp, 1'b0, 1'b0, 1'b1, ix));
        end
        chk("laps_two", 8'h8A);

        // Fault on a skipped step, then recovery via home pattern
        step(6'b010000);
        chk("fault_skip", 8'hB4);
        step(6'b000000);
        chk("fault_zero", 8'hB7);
        step(6'b100000);
        chk("fault_exit", 8'hA5);

        // Search count restarts after a reverse step
        step(6'b000001);
        chk("search_s1", 8'hA0);
        step(6'b000010);
        chk("search_s2", 8'hA1);
        step(6'b000001);
        chk("search_reverse", 8'hA0);
        step(6'b000010);
        chk("search_r1", 8'hA1);
        step(6'b000100);
        chk("search_r2", 8'hA2);
        step(6'b001000);
        chk("relock", 8'hAB);

        // Reset lands on the same edge as a wrap event
        step(6'b010000);
        chk("lock_ph4", 8'hAC);
        step(6'b100000);
        chk("lock_ph5", 8'hAD);
        ring = 6'b000001;
        tick(L - 1);
        chk("pre_wrap", 8'hAD);
        rst = 1'b1;
        tick(1);
        chk("rst_mid_lock", 8'h07);
        rst = 1'b0;
        tick(L);
        chk("post_rst", 8'h00);

`ifdef RING_GLITCH_FILTER_EN
        // One-clock pulse between stable values is ignored
        tick(2);
        ring = 6'b000010;
        tick(1);
        ring = 6'b000001;
        tick(6);
        chk("glitch_ignored", 8'h00);
        step(6'b000010);
        chk("after_glitch", 8'h01);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ring_chaser_monitor.md
Name: ring_chaser_monitor

Overview:
- Receive-side companion to the 6-bit one-hot ring chaser. Samples the chaser's six ring outputs on its own clock and checks that the pattern advances legally.
- Reports the current phase in binary, a lock indicator, fault flags and a 2-bit lap counter.
- Sits on a TinyTapeout 8-in/8-out user slot. Clock and reset are carried on io_in bits.

Parameters:
- SYNC_STAGES, 2: synchronizer depth on ring inputs (minimum 2).
- LOCK_COUNT, 3: consecutive legal steps required to enter LOCKED (range 1..7).

Ports:
- io_in[0]  input  1  clk; single clock, all state on rising edge.
- io_in[1]  input  1  rst; reset is synchronous and active-high.
- io_in[7:2]  input  6  ring[5:0] from chaser, asynchronous to clk.
- io_out[2:0]  output  3  phase index 0..5 of the set bit in the accepted ring value; 3'b111 if not one-hot.
- io_out[3]  output  1  locked (state == LOCKED).
- io_out[4]  output  1  fault (state == FAULT).
- io_out[5]  output  1  err_sticky; set on any illegal step, cleared only by rst.
- io_out[7:6]  output  2  lap count mod 4.

Behaviour:
- Legal step: next = {cur[4:0], cur[5]}, i.e. bit5->bit0->bit1->...->bit5. Reverse or skipped steps are illegal. Non-one-hot values (zero or multi-hot) are illegal.
- Synchronizer: ring passes through SYNC_STAGES flops to give ring_s. prev holds the last accepted value.
- Event: ring_s != prev. The event is evaluated and prev <= ring_s on the same edge.
- Latency: input change -> outputs updated SYNC_STAGES+1 clocks later (3 at default).
- Reset (rst=1 at edge): sync flops=0, prev=0, state=SEARCH, good_cnt=0, laps=0, err_sticky=0. io_out = 8'b0000_0111. rst dominates any simultaneous event, including mid-lock.
- SEARCH:
  - Event with legal step from prev: good_cnt++.
  - Any other event: good_cnt=0; err_sticky is not set while SEARCH.
  - good_cnt reaching LOCK_COUNT: -> LOCKED, good_cnt=0.
- LOCKED:
  - Legal event: stay. If new value == 6'b000001 (wrap from bit5), laps++ (wraps 3->0).
  - Illegal event: -> FAULT, err_sticky=1. prev still loads the bad value so the index shows 7 or the bad position.
  - No event: hold.
- FAULT:
  - Hold until ring_s == 6'b100000 (the chaser's reset pattern), then -> SEARCH with good_cnt=0.
  - laps is held, not cleared.
- Encoding: SEARCH=2'b00, LOCKED=2'b01, FAULT=2'b10. 2'b11 is illegal and recovers to SEARCH on the next edge.
- Index encoder: a pure function of prev, registered implicitly because prev is a register. No combinational path from io_in to io_out.

Optional Feature:
- Macro: RING_GLITCH_FILTER_EN.
- Defined: ring_s must be unchanged for 2 consecutive clocks before an event is qualified; shorter pulses are ignored. Latency becomes SYNC_STAGES+2 clocks.
- Undefined: every change of ring_s is an event. Latency is SYNC_STAGES+1.

Test Plan:
- Reset: hold rst=1 for 2 clocks with ring=6'b100000 -> io_out=8'h07. Release rst -> 3 clocks later io_out[2:0]=5, locked=0.
- Lock: from 6'b100000, step 000001, 000010, 000100, each held 4 clocks -> locked=1 exactly 3 clocks after the third step; index=2.
- Lap count: locked, run 12 further legal steps through two wraps -> laps=2 (io_out[7:6]=2'b10) after the second 100000->000001.
- Fault: locked at 000100, drive 010000 (skip) -> fault=1, err_sticky=1, locked=0. Drive 000000 -> index=7. Drive 100000 -> fault=0, state SEARCH. err_sticky stays 1 until rst.
- Search reset-of-count: two legal steps, then a reverse step -> still unlocked. Three further legal steps are needed to lock.
- Mid-operation reset: assert rst on the same edge as a legal wrap event -> laps=0, io_out=8'h07. RING_GLITCH_FILTER_EN build: a 1-clock 000010 pulse between 000001 holds -> no event, state unchanged.
